// File: rtl/zif_pulse_sched.sv
// zif_pulse_sched: queued sequencer that drives timed level/oe patterns onto ZIF pin groups.
// Defining ZIF_PULSE_SCHED_COUNT_EN adds an 8-bit done_count output.
module zif_pulse_sched #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PRESCALE = 24,
  parameter int unsigned USEC_W   = 12
) (
  input  logic                    osc,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_level,
  input  logic [7:0]              cmd_oe,
  input  logic [USEC_W-1:0]       cmd_usec,
  input  logic                    abort,
  output logic [7:0]              zif_out,
  output logic [7:0]              zif_oe,
  output logic                    busy,
  output logic                    done,
`ifdef ZIF_PULSE_SCHED_COUNT_EN
  output logic [7:0]              done_count,
`endif
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreLoad = PW'(PRESCALE - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  logic [7:0]        r_mem_level [DEPTH];
  logic [7:0]        r_mem_oe    [DEPTH];
  logic [USEC_W-1:0] r_mem_usec  [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_d;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  state_e            r_state;
  state_e            w_state_d;
  logic [PW-1:0]     r_pre;
  logic [PW-1:0]     w_pre_d;
  logic [USEC_W-1:0] r_us;
  logic [USEC_W-1:0] w_us_d;
  logic [7:0]        r_out;
  logic [7:0]        w_out_d;
  logic [7:0]        r_oe;
  logic [7:0]        w_oe_d;
  logic              w_expire;
  logic              w_done;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Readiness uses pre-edge occupancy; abort blocks pushes in its own cycle.
  assign cmd_ready = !w_full && !abort;
  assign w_push    = cmd_valid && cmd_ready;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + (AW+1)'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge osc) begin
    if (w_push) begin
      r_mem_level[r_wptr] <= cmd_level;
      r_mem_oe[r_wptr]    <= cmd_oe;
      r_mem_usec[r_wptr]  <= cmd_usec;
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_d;
    end
  end

  // A zero us count is only ever seen when the command was loaded with usec==0.
  assign w_expire = (r_us == '0) || ((r_us == USEC_W'(1)) && (r_pre == '0));

  always_comb begin
    w_state_d = r_state;
    w_pre_d   = r_pre;
    w_us_d    = r_us;
    w_out_d   = r_out;
    w_oe_d    = r_oe;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    if (abort) begin
      w_state_d = StIdle;
      w_oe_d    = '0;
      w_pre_d   = '0;
      w_us_d    = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_state_d = StHold;
          end
        end
        StHold: begin
          if (w_expire) begin
            w_done = 1'b1;
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_d = StIdle;
            end
          end else if (r_pre == '0) begin
            w_pre_d = PreLoad;
            w_us_d  = r_us - USEC_W'(1);
          end else begin
            w_pre_d = r_pre - PW'(1);
          end
        end
        default: w_state_d = StIdle;
      endcase
      if (w_pop) begin
        w_out_d = r_mem_level[r_rptr];
        w_oe_d  = r_mem_oe[r_rptr];
        w_us_d  = r_mem_usec[r_rptr];
        w_pre_d = PreLoad;
      end
    end
  end

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_pre   <= '0;
      r_us    <= '0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_state <= w_state_d;
      r_pre   <= w_pre_d;
      r_us    <= w_us_d;
      r_out   <= w_out_d;
      r_oe    <= w_oe_d;
    end
  end

`ifdef ZIF_PULSE_SCHED_COUNT_EN
  logic [7:0] r_done_cnt;

  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      r_done_cnt <= '0;
    end else if (abort) begin
      r_done_cnt <= '0;
    end else if (w_done) begin
      r_done_cnt <= r_done_cnt + 8'd1;
    end
  end

  assign done_count = r_done_cnt;
`endif

  assign zif_out    = r_out;
  assign zif_oe     = r_oe;
  assign busy       = !w_empty || (r_state != StIdle);
  assign done       = w_done;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_zif_pulse_sched.sv
// Scoreboard bench for zif_pulse_sched: a timeline model predicts when each command
// starts and completes; a monitor compares DUT outputs every cycle.
module tb_zif_pulse_sched;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PRESCALE = 24;
  localparam int unsigned USEC_W   = 12;

  logic              osc = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [7:0]        cmd_level = '0;
  logic [7:0]        cmd_oe = '0;
  logic [USEC_W-1:0] cmd_usec = '0;
  logic              abort = 1'b0;
  logic [7:0]        zif_out;
  logic [7:0]        zif_oe;
  logic              busy;
  logic              done;
  logic [$clog2(DEPTH):0] fifo_level;
`ifdef ZIF_PULSE_SCHED_COUNT_EN
  logic [7:0]        done_count;
`endif

  zif_pulse_sched #(
    .DEPTH    (DEPTH),
    .PRESCALE (PRESCALE),
    .USEC_W   (USEC_W)
  ) dut (
    .osc        (osc),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_level  (cmd_level),
    .cmd_oe     (cmd_oe),
    .cmd_usec   (cmd_usec),
    .abort      (abort),
    .zif_out    (zif_out),
    .zif_oe     (zif_oe),
    .busy       (busy),
    .done       (done),
`ifdef ZIF_PULSE_SCHED_COUNT_EN
    .done_count (done_count),
`endif
    .fifo_level (fifo_level)
  );

  always #5 osc = ~osc;

  typedef struct {
    int         start;      // edge at which the pattern is loaded
    int         done_edge;  // cycle (edges so far) during which done is high
    logic [7:0] level;
    logic [7:0] oe;
  } cmd_t;

  cmd_t live[$];
  cmd_t exp_q[$];

  int cyc = 0;
  always @(posedge osc) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_errs = 0;
  bit         mon_en = 1'b0;
  bit         exp_ready;
  bit         exp_busy;
  int         exp_level;
  logic [7:0] exp_out;
  logic [7:0] exp_oe;
  logic [7:0] last_out;
  logic [7:0] last_oe;
  int         last_end;
  int         model_dc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    live.delete();
    exp_q.delete();
    last_end  = 0;
    last_out  = '0;
    last_oe   = '0;
    model_dc  = 0;
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
    exp_level = 0;
    exp_out   = '0;
    exp_oe    = '0;
  endtask

  // One clock of stimulus; also advances the timeline model for this cycle.
  task automatic step(input bit v, input logic [7:0] lv, input logic [7:0] oe, input int us,
                      input bit ab, output bit acc);
    int c, occ, len, st;
    @(posedge osc);
    #1;
    c = cyc;
    while (live.size() != 0 && live[0].done_edge < c) void'(live.pop_front());
    occ = 0;
    foreach (live[i]) if (live[i].start > c) occ++;
    exp_ready = (occ < DEPTH) && !ab;
    exp_level = occ;
    exp_busy  = (live.size() != 0);
    if (live.size() != 0 && live[0].start <= c) begin
      last_out = live[0].level;
      last_oe  = live[0].oe;
    end
    exp_out   = last_out;
    exp_oe    = last_oe;
    cmd_valid = v;
    cmd_level = lv;
    cmd_oe    = oe;
    cmd_usec  = USEC_W'(us);
    abort     = ab;
    acc       = 1'b0;
    if (ab) begin
      live.delete();
      exp_q.delete();
      last_end = 0;
      last_oe  = '0;
    end else if (v && exp_ready) begin
      len = (us == 0) ? 1 : us * PRESCALE;
      st  = (c + 2 > last_end) ? c + 2 : last_end;
      live.push_back('{start: st, done_edge: st + len - 1, level: lv, oe: oe});
      exp_q.push_back('{start: st, done_edge: st + len - 1, level: lv, oe: oe});
      last_end = st + len;
      acc = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 0, 1'b0, a);
  endtask

  task automatic push(input logic [7:0] lv, input logic [7:0] oe, input int us);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 10000) begin
      step(1'b1, lv, oe, us, 1'b0, a);
      n++;
    end
    check("push_accept_timeout", {31'd0, a}, 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((live.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      idle(1);
      n++;
    end
    check("drain_timeout", {31'd0, (n < max_cyc)}, 32'd1);
    idle(2);
  endtask

  always @(negedge osc) begin
    bit expd;
    if (mon_en) begin
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
      check("fifo_level", 32'(fifo_level), 32'(exp_level));
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("zif_out", {24'd0, zif_out}, {24'd0, exp_out});
      check("zif_oe", {24'd0, zif_oe}, {24'd0, exp_oe});
`ifdef ZIF_PULSE_SCHED_COUNT_EN
      check("done_count", {24'd0, done_count}, {24'd0, 8'(model_dc)});
`endif
      expd = (exp_q.size() != 0) && (exp_q[0].done_edge == cyc);
      check("done", {31'd0, done}, {31'd0, expd});
      if (expd) begin
        check("done_level", {24'd0, zif_out}, {24'd0, exp_q[0].level});
        check("done_oe", {24'd0, zif_oe}, {24'd0, exp_q[0].oe});
        void'(exp_q.pop_front());
        model_dc++;
      end
      if (abort) model_dc = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    model_reset();
    // Reset asserted mid-clock: outputs must clear without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_zif_out", {24'd0, zif_out}, 32'd0);
    check("rst_zif_oe", {24'd0, zif_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    @(posedge osc);
    @(posedge osc);
    #1 rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(2);

    // Single command, 2 us.
    push(8'hA5, 8'hFF, 2);
    drain(2000);

    // Back-to-back with backpressure: six 1 us commands into a depth-4 FIFO.
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i), 8'(8'hF0 | i), 1);
    drain(2000);

    // Zero durations followed by 3 us.
    push(8'h11, 8'h01, 0);
    push(8'h22, 8'h02, 0);
    push(8'h33, 8'h03, 3);
    drain(2000);

    // Abort ten cycles into the first of three queued commands.
    push(8'h5A, 8'hAA, 2);
    push(8'h6B, 8'hBB, 2);
    push(8'h7C, 8'hCC, 2);
    idle(9);
    step(1'b1, 8'h99, 8'h99, 1, 1'b1, a);
    idle(3);
    drain(2000);

    // 257 zero-duration commands exercise the done counter wrap.
    for (int i = 0; i < 257; i++) push(8'(i), 8'(~i), 0);
    drain(4000);

    // Randomized traffic with occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           ($urandom_range(0, 199) == 0), a);
    end
    drain(20000);

    // Reset mid-HOLD.
    push(8'h3C, 8'h0F, 2);
    idle(10);
    @(posedge osc);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_zif_out", {24'd0, zif_out}, 32'd0);
    check("midrst_zif_oe", {24'd0, zif_oe}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_fifo_level", 32'(fifo_level), 32'd0);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(posedge osc);
    #1 rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(4);
    push(8'hC3, 8'h81, 1);
    drain(2000);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
